// File: rtl/flash_boot_loader_param.sv
// flash_boot_loader_param
// Power-on image loader. Copies RAM_WORDS words of one flash page into the code
// RAM through an Avalon-MM read master, optionally byte-reversing each word and
// keeping an additive checksum of the written words. Once the image is in place
// it raises done and answers single-byte flash reads until a reload is requested.
module flash_boot_loader_param #(
    parameter int DATA_WIDTH = 32,
    parameter int RAM_WORDS  = 4096,
    parameter int PAGE_WIDTH = 4,
    parameter int FLASH_AW   = 16,
    parameter int GAP_CYCLES = 3,
    parameter int BYTE_SWAP  = 1,
    localparam int RAM_AW    = $clog2(RAM_WORDS),
    localparam int BYTES     = DATA_WIDTH / 8,
    localparam int LANE_SH   = $clog2(BYTES),
    localparam int BYTE_AW   = $clog2(RAM_WORDS * BYTES)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [PAGE_WIDTH-1:0] page_index,
    input  logic                  reload,
    output logic [FLASH_AW-1:0]   flash_addr,
    output logic                  flash_read,
    input  logic                  flash_waitrequest,
    input  logic [DATA_WIDTH-1:0] flash_readdata,
    input  logic                  flash_readdatavalid,
    output logic                  ram_we,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum,
    input  logic                  rd_req,
    input  logic [BYTE_AW-1:0]    rd_byte_addr,
    output logic                  rd_valid,
    output logic [7:0]            rd_byte
);

    localparam int LANE_W = (LANE_SH > 0) ? LANE_SH : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [LANE_W-1:0] LANE_MASK = LANE_W'((1 << LANE_SH) - 1);
    localparam logic [RAM_AW-1:0] LAST_IDX  = RAM_AW'(RAM_WORDS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ISSUE     = 4'd1,
        ST_WAIT_DATA = 4'd2,
        ST_WRITE     = 4'd3,
        ST_GAP       = 4'd4,
        ST_END       = 4'd5,
        ST_SERVE     = 4'd6,
        ST_SRV_ISSUE = 4'd7,
        ST_SRV_WAIT  = 4'd8
    } state_t;

    state_t                state_q,      state_d;
    logic [RAM_AW-1:0]     word_idx_q,   word_idx_d;
    logic [PAGE_WIDTH-1:0] page_l_q,     page_l_d;
    logic [GAP_W-1:0]      gap_cnt_q,    gap_cnt_d;
    logic [LANE_W-1:0]     rd_lane_q,    rd_lane_d;
    logic                  flash_read_q, flash_read_d;
    logic [FLASH_AW-1:0]   flash_addr_q, flash_addr_d;
    logic                  ram_we_q,     ram_we_d;
    logic [RAM_AW-1:0]     ram_addr_q,   ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q,  ram_wdata_d;
    logic                  busy_q,       busy_d;
    logic                  done_q,       done_d;
    logic [DATA_WIDTH-1:0] checksum_q,   checksum_d;
    logic                  rd_valid_q,   rd_valid_d;
    logic [7:0]            rd_byte_q,    rd_byte_d;

    logic [DATA_WIDTH-1:0] loaded_s;
    logic [RAM_AW-1:0]     next_idx_s;

    // Reverse byte order: lane 0 of the result is the top lane of the input.
    function automatic logic [DATA_WIDTH-1:0] swap_bytes(input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int b = 0; b < BYTES; b++) begin
            r[8*b +: 8] = w[DATA_WIDTH-8-8*b +: 8];
        end
        return r;
    endfunction

    // Word as it is stored into RAM for this build.
    function automatic logic [DATA_WIDTH-1:0] load_word(input logic [DATA_WIDTH-1:0] w);
        if (BYTE_SWAP != 0) begin
            return swap_bytes(w);
        end else begin
            return w;
        end
    endfunction

    // Flash word address {zeros, page, word}.
    function automatic logic [FLASH_AW-1:0] make_addr(input logic [PAGE_WIDTH-1:0] pg,
                                                      input logic [RAM_AW-1:0]     wd);
        return FLASH_AW'({pg, wd});
    endfunction

    // Next-state and next-output logic for the load / serve sequencer.
    always_comb begin
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        page_l_d     = page_l_q;
        gap_cnt_d    = gap_cnt_q;
        rd_lane_d    = rd_lane_q;
        flash_read_d = flash_read_q;
        flash_addr_d = flash_addr_q;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        busy_d       = busy_q;
        done_d       = done_q;
        checksum_d   = checksum_q;
        rd_valid_d   = 1'b0;
        rd_byte_d    = rd_byte_q;
        loaded_s     = load_word(flash_readdata);
        next_idx_s   = word_idx_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                // Automatic power-on load of the page presented at reset release.
                state_d      = ST_ISSUE;
                word_idx_d   = {RAM_AW{1'b0}};
                page_l_d     = page_index;
                checksum_d   = {DATA_WIDTH{1'b0}};
                busy_d       = 1'b1;
                done_d       = 1'b0;
                flash_read_d = 1'b1;
                flash_addr_d = make_addr(page_index, {RAM_AW{1'b0}});
            end

            ST_ISSUE: begin
                // Address and read strobe stay put until the slave stops stalling.
                if (flash_waitrequest) begin
                    state_d = ST_ISSUE;
                end else begin
                    flash_read_d = 1'b0;
                    state_d      = ST_WAIT_DATA;
                end
            end

            ST_WAIT_DATA: begin
                if (flash_readdatavalid) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = word_idx_q;
                    ram_wdata_d = loaded_s;
                    checksum_d  = checksum_q + loaded_s;
                    state_d     = ST_WRITE;
                end else begin
                    state_d = ST_WAIT_DATA;
                end
            end

            ST_WRITE: begin
                // ram_we is high during this state; decide what follows the write.
                if (word_idx_q == LAST_IDX) begin
                    state_d = ST_END;
                end else if (GAP_CYCLES == 0) begin
                    word_idx_d   = next_idx_s;
                    flash_read_d = 1'b1;
                    flash_addr_d = make_addr(page_l_q, next_idx_s);
                    state_d      = ST_ISSUE;
                end else begin
                    gap_cnt_d = {GAP_W{1'b0}};
                    state_d   = ST_GAP;
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    word_idx_d   = next_idx_s;
                    flash_read_d = 1'b1;
                    flash_addr_d = make_addr(page_l_q, next_idx_s);
                    state_d      = ST_ISSUE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                    state_d   = ST_GAP;
                end
            end

            ST_END: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_SERVE;
            end

            ST_SERVE: begin
                // A reload takes priority over a byte read requested in the same cycle.
                if (reload) begin
                    state_d      = ST_ISSUE;
                    word_idx_d   = {RAM_AW{1'b0}};
                    page_l_d     = page_index;
                    checksum_d   = {DATA_WIDTH{1'b0}};
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    flash_read_d = 1'b1;
                    flash_addr_d = make_addr(page_index, {RAM_AW{1'b0}});
                end else if (rd_req) begin
                    rd_lane_d    = LANE_W'(rd_byte_addr) & LANE_MASK;
                    flash_read_d = 1'b1;
                    flash_addr_d = make_addr(page_index, RAM_AW'(rd_byte_addr >> LANE_SH));
                    state_d      = ST_SRV_ISSUE;
                end else begin
                    state_d = ST_SERVE;
                end
            end

            ST_SRV_ISSUE: begin
                if (flash_waitrequest) begin
                    state_d = ST_SRV_ISSUE;
                end else begin
                    flash_read_d = 1'b0;
                    state_d      = ST_SRV_WAIT;
                end
            end

            ST_SRV_WAIT: begin
                // Raw flash byte, lane 0 in bits 7:0; no swap on this path.
                if (flash_readdatavalid) begin
                    rd_valid_d = 1'b1;
                    rd_byte_d  = 8'(flash_readdata >> {rd_lane_q, 3'b000});
                    state_d    = ST_SERVE;
                end else begin
                    state_d = ST_SRV_WAIT;
                end
            end

            default: begin
                flash_read_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and output registers; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            word_idx_q   <= {RAM_AW{1'b0}};
            page_l_q     <= {PAGE_WIDTH{1'b0}};
            gap_cnt_q    <= {GAP_W{1'b0}};
            rd_lane_q    <= {LANE_W{1'b0}};
            flash_read_q <= 1'b0;
            flash_addr_q <= {FLASH_AW{1'b0}};
            ram_we_q     <= 1'b0;
            ram_addr_q   <= {RAM_AW{1'b0}};
            ram_wdata_q  <= {DATA_WIDTH{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            checksum_q   <= {DATA_WIDTH{1'b0}};
            rd_valid_q   <= 1'b0;
            rd_byte_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            page_l_q     <= page_l_d;
            gap_cnt_q    <= gap_cnt_d;
            rd_lane_q    <= rd_lane_d;
            flash_read_q <= flash_read_d;
            flash_addr_q <= flash_addr_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            checksum_q   <= checksum_d;
            rd_valid_q   <= rd_valid_d;
            rd_byte_q    <= rd_byte_d;
        end
    end

    assign flash_addr = flash_addr_q;
    assign flash_read = flash_read_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign checksum   = checksum_q;
    assign rd_valid   = rd_valid_q;
    assign rd_byte    = rd_byte_q;

endmodule

// File: tb/tb_flash_boot_loader_param.sv
// Bench for flash_boot_loader_param: a flash responder with optional random
// stalls/latency/stray valids, a write/read capture, and an image model built
// from the flash contents formula.
module tb_flash_boot_loader_param;

    localparam int RW  = 16;
    localparam int GAP = 3;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // main instance (byte swap, gap 3)
    logic [3:0]  page_index;
    logic        reload;
    logic [15:0] flash_addr;
    logic        flash_read;
    logic        flash_waitrequest;
    logic [31:0] flash_readdata;
    logic        flash_readdatavalid;
    logic        ram_we;
    logic [3:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        busy, done;
    logic [31:0] checksum;
    logic        rd_req;
    logic [5:0]  rd_byte_addr;
    logic        rd_valid;
    logic [7:0]  rd_byte;

    // second instance (no swap, no gap)
    logic [3:0]  page_index2;
    logic        reload2;
    logic [15:0] flash_addr2;
    logic        flash_read2;
    logic        flash_waitrequest2;
    logic [31:0] flash_readdata2;
    logic        flash_readdatavalid2;
    logic        ram_we2;
    logic [3:0]  ram_addr2;
    logic [31:0] ram_wdata2;
    logic        busy2, done2;
    logic [31:0] checksum2;
    logic        rd_req2;
    logic [5:0]  rd_byte_addr2;
    logic        rd_valid2;
    logic [7:0]  rd_byte2;

    flash_boot_loader_param #(.DATA_WIDTH(32), .RAM_WORDS(RW), .PAGE_WIDTH(4), .FLASH_AW(16),
                              .GAP_CYCLES(GAP), .BYTE_SWAP(1)) dut (
        .clk(clk), .reset_n(reset_n), .page_index(page_index), .reload(reload),
        .flash_addr(flash_addr), .flash_read(flash_read), .flash_waitrequest(flash_waitrequest),
        .flash_readdata(flash_readdata), .flash_readdatavalid(flash_readdatavalid),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .busy(busy), .done(done),
        .checksum(checksum), .rd_req(rd_req), .rd_byte_addr(rd_byte_addr),
        .rd_valid(rd_valid), .rd_byte(rd_byte));

    flash_boot_loader_param #(.DATA_WIDTH(32), .RAM_WORDS(RW), .PAGE_WIDTH(4), .FLASH_AW(16),
                              .GAP_CYCLES(0), .BYTE_SWAP(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .page_index(page_index2), .reload(reload2),
        .flash_addr(flash_addr2), .flash_read(flash_read2), .flash_waitrequest(flash_waitrequest2),
        .flash_readdata(flash_readdata2), .flash_readdatavalid(flash_readdatavalid2),
        .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .busy(busy2), .done(done2),
        .checksum(checksum2), .rd_req(rd_req2), .rd_byte_addr(rd_byte_addr2),
        .rd_valid(rd_valid2), .rd_byte(rd_byte2));

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] flash_word(input int unsigned a);
        return a * 32'h01010101 + 32'h00010203;
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] img_word(input int pg, input int i, input bit swap);
        logic [31:0] w;
        w = flash_word(pg * RW + i);
        return swap ? bswap(w) : w;
    endfunction

    function automatic logic [31:0] img_sum(input int pg, input bit swap);
        logic [31:0] s;
        s = 32'h0;
        for (int i = 0; i < RW; i++) s = s + img_word(pg, i, swap);
        return s;
    endfunction

    function automatic logic [7:0] flash_byte(input int pg, input int ba);
        logic [31:0] w;
        w = flash_word(pg * RW + ba / 4);
        return w[8 * (ba % 4) +: 8];
    endfunction

    // ---------------- flash responder for the main instance ----------------
    bit          stall_en = 1'b0;
    bit          stray_en = 1'b0;
    bit          pend = 1'b0;
    bit          in_req = 1'b0;
    int          stall_left = 0;
    int          lat = 0;
    logic [15:0] paddr = 16'h0;
    logic [15:0] req_addr = 16'h0;

    // Drives waitrequest/readdata/readdatavalid between active edges.
    always @(negedge clk) begin
        flash_readdatavalid = 1'b0;
        flash_readdata      = $urandom;
        if (!reset_n) begin
            pend = 1'b0; in_req = 1'b0; flash_waitrequest = 1'b0;
        end else begin
            if (pend) begin
                if (lat == 0) begin
                    flash_readdatavalid = 1'b1;
                    flash_readdata      = flash_word(paddr);
                    pend                = 1'b0;
                end else begin
                    lat--;
                end
            end else if (stray_en && !flash_read && $urandom_range(0, 3) == 0) begin
                flash_readdatavalid = 1'b1;
            end
            if (flash_read) begin
                tests++;
                if (pend) begin
                    fails++;
                    $display("FAIL one_outstanding: flash_read=1 with a read pending, required 0");
                end
                if (!in_req) begin
                    in_req     = 1'b1;
                    req_addr   = flash_addr;
                    stall_left = stall_en ? int'($urandom_range(0, 4)) : 0;
                end else begin
                    tests++;
                    if (flash_addr !== req_addr) begin
                        fails++;
                        $display("FAIL addr_stable: flash_addr=%h required %h", flash_addr, req_addr);
                    end
                end
                if (stall_left > 0) begin
                    flash_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    flash_waitrequest = 1'b0;
                    pend   = 1'b1;
                    paddr  = flash_addr;
                    lat    = stall_en ? int'($urandom_range(0, 4)) : 0;
                    in_req = 1'b0;
                end
            end else begin
                flash_waitrequest = 1'b0;
                in_req = 1'b0;
            end
        end
    end

    // ---------------- flash responder for the second instance ----------------
    bit          pend2 = 1'b0;
    logic [15:0] paddr2 = 16'h0;

    // Zero-stall, one-cycle-latency responder.
    always @(negedge clk) begin
        flash_readdatavalid2 = 1'b0;
        flash_readdata2      = $urandom;
        flash_waitrequest2   = 1'b0;
        if (!reset_n) begin
            pend2 = 1'b0;
        end else begin
            if (pend2) begin
                flash_readdatavalid2 = 1'b1;
                flash_readdata2      = flash_word(paddr2);
                pend2                = 1'b0;
            end
            if (flash_read2) begin
                pend2  = 1'b1;
                paddr2 = flash_addr2;
            end
        end
    end

    // ---------------- capture ----------------
    logic [3:0]  wr_a[$];
    logic [31:0] wr_d[$];
    int          cyc = 0;
    int          last_we = 0;
    bit          wr_since = 1'b0;
    bit          prev_read = 1'b0;
    int          rdv_cnt = 0;
    logic [7:0]  last_byte = 8'h00;
    logic [31:0] img2[RW];
    int          n2 = 0;

    // Records RAM writes, byte-read results and read-strobe spacing.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            wr_since  = 1'b0;
            prev_read = 1'b0;
        end else begin
            if (ram_we) begin
                wr_a.push_back(ram_addr);
                wr_d.push_back(ram_wdata);
                last_we  = cyc;
                wr_since = 1'b1;
                tests++;
                if (!busy) begin
                    fails++;
                    $display("FAIL ram_we_outside_load: busy=%0b required 1", busy);
                end
            end
            if (rd_valid) begin
                rdv_cnt++;
                last_byte = rd_byte;
            end
            if (flash_read && !prev_read && busy && wr_since) begin
                tests++;
                if (cyc - last_we - 1 != GAP) begin
                    fails++;
                    $display("FAIL gap_cycles: idle=%0d required %0d", cyc - last_we - 1, GAP);
                end
                wr_since = 1'b0;
            end
            if (!busy) wr_since = 1'b0;
            prev_read = flash_read;
        end
        if (reset_n && ram_we2) begin
            img2[ram_addr2] = ram_wdata2;
            n2++;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic clear_caps();
        wr_a.delete();
        wr_d.delete();
    endtask

    task automatic check_load(input int pg, input string nm);
        int n;
        logic [31:0] es;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(done === 1'b1, {nm, "_done"}, 64'(done), 64'd1);
        check(wr_a.size() == RW, {nm, "_wr_count"}, 64'(wr_a.size()), 64'(RW));
        for (int i = 0; i < RW && i < wr_a.size(); i++) begin
            check(wr_a[i] === 4'(i), {nm, "_wr_addr"}, 64'(wr_a[i]), 64'(i));
            check(wr_d[i] === img_word(pg, i, 1'b1), {nm, "_wr_data"}, 64'(wr_d[i]),
                  64'(img_word(pg, i, 1'b1)));
        end
        es = img_sum(pg, 1'b1);
        check(checksum === es, {nm, "_checksum"}, 64'(checksum), 64'(es));
        check(busy === 1'b0, {nm, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    task automatic byte_read(input logic [3:0] pg, input logic [5:0] ba, input logic [7:0] exp,
                             input string nm);
        int c0;
        int n;
        c0 = rdv_cnt;
        n  = 0;
        page_index   = pg;
        rd_byte_addr = ba;
        rd_req       = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        while (rdv_cnt == c0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(rdv_cnt != c0, {nm, "_rd_valid"}, 64'(rdv_cnt - c0), 64'd1);
        if (rdv_cnt != c0) check(last_byte === exp, {nm, "_rd_byte"}, 64'(last_byte), 64'(exp));
    endtask

    typedef struct {
        logic [3:0] page;
        logic [5:0] baddr;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t vecs[5];

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0]  rp;
        logic [5:0]  rb;
        logic [31:0] s2;
        int          c0;
        int          n;

        vecs[0] = '{4'd2, 6'd0, 8'h23};
        vecs[1] = '{4'd2, 6'd1, 8'h22};
        vecs[2] = '{4'd2, 6'd2, 8'h21};
        vecs[3] = '{4'd2, 6'd3, 8'h20};
        vecs[4] = '{4'd2, 6'd7, 8'h21};

        reset_n = 1'b0; page_index = 4'd0; reload = 1'b0; rd_req = 1'b0; rd_byte_addr = 6'd0;
        page_index2 = 4'd5; reload2 = 1'b0; rd_req2 = 1'b0; rd_byte_addr2 = 6'd0;
        repeat (3) @(negedge clk);
        check({flash_addr, flash_read, ram_we, ram_addr, ram_wdata, busy, done, checksum,
               rd_valid, rd_byte} === '0, "reset_state", 64'({flash_read, ram_we, busy, done, rd_valid}),
              64'd0);

        // 1: power-on load of page 0, no stalls
        clear_caps();
        reset_n = 1'b1;
        @(negedge clk);
        check(busy === 1'b1 && flash_read === 1'b1 && flash_addr === 16'h0000, "t1_first_issue",
              64'({busy, flash_read, flash_addr}), 64'({1'b1, 1'b1, 16'h0000}));
        check_load(0, "t1");

        // BYTE_SWAP=0 / GAP_CYCLES=0 build loads page 5 raw
        n = 0;
        while (!done2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(done2 === 1'b1 && n2 == RW, "t6_raw_done", 64'({done2, n2[15:0]}), 64'({1'b1, 16'(RW)}));
        for (int i = 0; i < RW; i++)
            check(img2[i] === img_word(5, i, 1'b0), "t6_raw_word", 64'(img2[i]), 64'(img_word(5, i, 1'b0)));
        s2 = img_sum(5, 1'b0);
        check(checksum2 === s2, "t6_raw_checksum", 64'(checksum2), 64'(s2));

        // 2: reload page 0 with random stalls, latency and stray valids
        stall_en = 1'b1; stray_en = 1'b1;
        clear_caps();
        page_index = 4'd0; reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check(done === 1'b0 && busy === 1'b1, "t2_reload_flags", 64'({done, busy}), 64'({1'b0, 1'b1}));
        check_load(0, "t2");

        // 3: byte reads from page 2 (table), no stalls
        stall_en = 1'b0; stray_en = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) byte_read(vecs[i].page, vecs[i].baddr, vecs[i].exp, "t3_table");

        // rd_req held through SERVE_WAIT yields exactly one rd_valid
        repeat (2) @(negedge clk);
        c0 = rdv_cnt;
        page_index = 4'd2; rd_byte_addr = 6'd5; rd_req = 1'b1;
        repeat (3) @(negedge clk);
        rd_req = 1'b0;
        repeat (20) @(negedge clk);
        check(rdv_cnt - c0 == 1, "t3_no_extra_rd_valid", 64'(rdv_cnt - c0), 64'd1);
        check(last_byte === 8'h23, "t3_held_rd_byte", 64'(last_byte), 64'h23);

        // randomized byte reads under stalls against the model
        stall_en = 1'b1; stray_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rp = 4'($urandom_range(0, 15));
            rb = 6'($urandom_range(0, 63));
            byte_read(rp, rb, flash_byte(rp, rb), "rand_read");
        end

        // 4: reload page 1
        repeat (2) @(negedge clk);
        clear_caps();
        page_index = 4'd1; reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check(done === 1'b0 && busy === 1'b1, "t4_reload_flags", 64'({done, busy}), 64'({1'b0, 1'b1}));
        check_load(1, "t4");

        // 5: reset during word 7 of a load, then full load from word 0
        stall_en = 1'b0; stray_en = 1'b0;
        repeat (2) @(negedge clk);
        clear_caps();
        page_index = 4'd7; reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        n = 0;
        while (wr_a.size() < 7 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(wr_a.size() >= 7, "t5_reach_word7", 64'(wr_a.size()), 64'd7);
        reset_n = 1'b0;
        #1;
        check({flash_addr, flash_read, ram_we, ram_addr, ram_wdata, busy, done, checksum,
               rd_valid, rd_byte} === '0, "t5_reset_outputs", 64'({flash_read, ram_we, busy, done}), 64'd0);
        @(negedge clk);
        page_index = 4'd6;
        clear_caps();
        reset_n = 1'b1;
        check_load(6, "t5");

        // 6: reload and rd_req together: load restarts, no rd_valid
        repeat (2) @(negedge clk);
        clear_caps();
        c0 = rdv_cnt;
        page_index = 4'd3; rd_byte_addr = 6'd4; reload = 1'b1; rd_req = 1'b1;
        @(negedge clk);
        reload = 1'b0; rd_req = 1'b0;
        check(done === 1'b0 && busy === 1'b1, "t6_reload_wins", 64'({done, busy}), 64'({1'b0, 1'b1}));
        check_load(3, "t6");
        check(rdv_cnt == c0, "t6_no_rd_valid", 64'(rdv_cnt - c0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
